// File: rtl/rtc_bus_reader_if.sv
// Multiplexed address/data bus between the RTC chip pads and its bus master.
// The master drives the strobes and the AD value; the chip side returns AD read data.
interface rtc_bus_reader_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/rtc_bus_reader.sv
// Periodically sweeps the RTC time/date/timer/status registers into a shadow copy,
// then publishes decoded BCD digits and flags to the clock screen in a single cycle.
module rtc_bus_reader #(
    parameter int T_PHASE        = 4,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pause,
    rtc_bus_reader_if.master        bus,
    output logic [23:0]             hora_bcd,
    output logic [23:0]             fecha_bcd,
    output logic [23:0]             timer_bcd,
    output logic [2:0]              dia_semana,
    output logic                    AM_PM,
    output logic                    formato_hora,
    output logic                    timer_end,
    output logic                    busy,
    output logic                    sweep_done
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int PH_W  = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [PH_W-1:0]  PHASE_LAST   = PH_W'(T_PHASE - 1);
    localparam logic [3:0]       LAST_INDEX   = 4'd10;

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_REL, DATA, GAP, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  refresh_q, refresh_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [3:0]        index_q, index_d;
    logic              capture, commit;
    logic [7:0]        shadow [0:10];
    logic              phase_last;
    logic [7:0]        hour_byte, timer_hour_byte;
    logic [3:0]        hour_tens;
    logic              unused_bits;

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_addr = 8'h21;
            4'd1:    reg_addr = 8'h22;
            4'd2:    reg_addr = 8'h23;
            4'd3:    reg_addr = 8'h24;
            4'd4:    reg_addr = 8'h25;
            4'd5:    reg_addr = 8'h26;
            4'd6:    reg_addr = 8'h27;
            4'd7:    reg_addr = 8'h41;
            4'd8:    reg_addr = 8'h42;
            4'd9:    reg_addr = 8'h43;
            4'd10:   reg_addr = 8'h01;
            default: reg_addr = 8'h00;
        endcase
    endfunction

    assign phase_last = (phase_q == PHASE_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            refresh_q <= '0;
            phase_q   <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
            phase_q   <= phase_d;
            index_q   <= index_d;
        end
    end

    // A pause at the end of a GAP parks the bus idle with the phase counter held,
    // so the sweep resumes at the next register as soon as pause drops.
    always_comb begin
        state_d   = state_q;
        refresh_d = refresh_q;
        phase_d   = phase_q;
        index_d   = index_q;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (refresh_q == REFRESH_LAST) begin
                    if (!pause) begin
                        refresh_d = '0;
                        index_d   = '0;
                        phase_d   = '0;
                        state_d   = ADDR;
                    end
                end else begin
                    refresh_d = refresh_q + CNT_W'(1);
                end
            end
            ADDR, ADDR_REL, DATA: begin
                capture = (state_q == DATA) && phase_last;
                if (phase_last) begin
                    phase_d = '0;
                    state_d = (state_q == ADDR) ? ADDR_REL :
                              (state_q == ADDR_REL) ? DATA : GAP;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            GAP: begin
                if (phase_last) begin
                    if (index_q == LAST_INDEX) begin
                        phase_d = '0;
                        commit  = 1'b1;
                        state_d = COMMIT;
                    end else if (!pause) begin
                        phase_d = '0;
                        index_d = index_q + 4'd1;
                        state_d = ADDR;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            COMMIT: begin
                refresh_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 11; i++) shadow[i] <= '0;
        end else if (capture) begin
            shadow[index_q] <= bus.ad_in;
        end
    end

    // In 12 h mode bit 5 is the PM flag, so only bit 4 belongs to the hour tens.
    assign hour_byte       = shadow[2];
    assign timer_hour_byte = shadow[9];
    assign hour_tens       = hour_byte[7] ? {3'b000, hour_byte[4]} : {2'b00, hour_byte[5:4]};
    assign unused_bits     = ^{shadow[6][7:3], timer_hour_byte[7:6], shadow[10][7:1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hora_bcd     <= '0;
            fecha_bcd    <= '0;
            timer_bcd    <= '0;
            dia_semana   <= '0;
            AM_PM        <= 1'b0;
            formato_hora <= 1'b0;
            timer_end    <= 1'b0;
        end else if (commit) begin
            hora_bcd     <= {hour_tens, hour_byte[3:0], shadow[1], shadow[0]};
            fecha_bcd    <= {shadow[3], shadow[4], shadow[5]};
            timer_bcd    <= {2'b00, timer_hour_byte[5:4], timer_hour_byte[3:0], shadow[8], shadow[7]};
            dia_semana   <= shadow[6][2:0];
            AM_PM        <= hour_byte[7] & hour_byte[5];
            formato_hora <= hour_byte[7];
            timer_end    <= shadow[10][0];
        end
    end

    assign bus.cs_n   = !(state_q == ADDR || state_q == ADDR_REL || state_q == DATA);
    assign bus.a_d    = (state_q == ADDR || state_q == ADDR_REL);
    assign bus.ad_oe  = (state_q == ADDR || state_q == ADDR_REL);
    assign bus.wr_n   = (state_q != ADDR);
    assign bus.rd_n   = (state_q != DATA);
    assign bus.ad_out = bus.a_d ? reg_addr(index_q) : 8'h00;
    assign busy       = (state_q != IDLE);
    assign sweep_done = (state_q == COMMIT);

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Self-checking bench for rtc_bus_reader: an RTC register-file model on the bus,
// table-driven and randomized sweeps against a decode model, plus timing corner cases.
module tb_rtc_bus_reader;

    localparam int T_PHASE = 2;
    localparam int REFRESH = 10;

    typedef struct {
        logic [23:0] hora;
        logic [23:0] fecha;
        logic [23:0] timer;
        logic [2:0]  dia;
        logic        ampm;
        logic        fmt;
        logic        tend;
    } exp_t;

    typedef struct {
        logic [10:0][7:0] regs;
        exp_t             e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic [23:0] hora_bcd, fecha_bcd, timer_bcd;
    logic [2:0]  dia_semana;
    logic        AM_PM, formato_hora, timer_end, busy, sweep_done;

    int checks = 0;
    int errors = 0;

    rtc_bus_reader_if bus ();

    rtc_bus_reader #(.T_PHASE(T_PHASE), .REFRESH_CYCLES(REFRESH)) dut (
        .clock(clock),
        .reset(reset),
        .pause(pause),
        .bus(bus),
        .hora_bcd(hora_bcd),
        .fecha_bcd(fecha_bcd),
        .timer_bcd(timer_bcd),
        .dia_semana(dia_semana),
        .AM_PM(AM_PM),
        .formato_hora(formato_hora),
        .timer_end(timer_end),
        .busy(busy),
        .sweep_done(sweep_done)
    );

    always #5 clock = ~clock;

    // RTC chip model: latches the address on the write strobe, returns data while rd_n is low.
    logic [7:0] rtc_regs [0:255];
    logic [7:0] latched_addr = 8'h00;
    logic [7:0] addr_map [0:10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                                    8'h41, 8'h42, 8'h43, 8'h01};

    always @(posedge clock)
        if (!bus.cs_n && bus.a_d && !bus.wr_n) latched_addr <= bus.ad_out;

    assign bus.ad_in = !bus.rd_n ? rtc_regs[latched_addr] : 8'hFF;

    // Continuous bus-rule and output-stability monitor.
    logic [77:0] cur_outs, prev_outs = '0;
    logic        prev_rst = 1'b0;
    assign cur_outs = {hora_bcd, fecha_bcd, timer_bcd, dia_semana, AM_PM, formato_hora, timer_end};

    always @(negedge clock) begin
        checks++;
        if ((bus.ad_oe && !bus.rd_n) || (!bus.cs_n && !bus.a_d && bus.rd_n)) begin
            errors++;
            $display("[TB] FAIL bus_rule at %0t: ad_oe=%0b rd_n=%0b cs_n=%0b a_d=%0b, required no oe while reading and cs only in addr/data",
                     $time, bus.ad_oe, bus.rd_n, bus.cs_n, bus.a_d);
        end
        if (reset && prev_rst) begin
            checks++;
            if (cur_outs !== prev_outs && !sweep_done) begin
                errors++;
                $display("[TB] FAIL output_stable at %0t: outputs 0x%0h changed from 0x%0h without sweep_done",
                         $time, cur_outs, prev_outs);
            end
        end
        prev_outs = cur_outs;
        prev_rst  = reset;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference decode derived from the register meanings with plain arithmetic.
    function automatic exp_t model(input logic [10:0][7:0] r);
        exp_t m;
        int   hour, tens, th;
        hour   = int'(r[2]);
        m.fmt  = (hour >= 128);
        if (m.fmt) begin
            m.ampm = ((hour % 64) >= 32);
            tens   = (hour / 16) % 2;
        end else begin
            m.ampm = 1'b0;
            tens   = (hour / 16) % 4;
        end
        m.hora  = 24'(((tens * 16 + hour % 16) * 65536) + int'(r[1]) * 256 + int'(r[0]));
        m.fecha = 24'(int'(r[3]) * 65536 + int'(r[4]) * 256 + int'(r[5]));
        th      = int'(r[9]);
        m.timer = 24'((((th / 16) % 4) * 16 + th % 16) * 65536 + int'(r[8]) * 256 + int'(r[7]));
        m.dia   = 3'(int'(r[6]) % 8);
        m.tend  = (int'(r[10]) % 2) == 1;
        return m;
    endfunction

    task automatic apply_stimulus(input logic [10:0][7:0] r);
        for (int i = 0; i < 11; i++) rtc_regs[addr_map[i]] = r[i];
    endtask

    task automatic check_output(input string tag, input exp_t e);
        check({tag, "_hora"},  32'(hora_bcd),     32'(e.hora));
        check({tag, "_fecha"}, 32'(fecha_bcd),    32'(e.fecha));
        check({tag, "_timer"}, 32'(timer_bcd),    32'(e.timer));
        check({tag, "_dia"},   32'(dia_semana),   32'(e.dia));
        check({tag, "_ampm"},  32'(AM_PM),        32'(e.ampm));
        check({tag, "_fmt"},   32'(formato_hora), 32'(e.fmt));
        check({tag, "_tend"},  32'(timer_end),    32'(e.tend));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sweep_done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check("sweep_done_seen", 32'(sweep_done), 32'd1);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (bus.cs_n !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check("sweep_start_seen", 32'(bus.cs_n), 32'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] sec, min, hour, day, mon, yr, wd, ts, tm, th, st,
                                input logic [23:0] hora, fecha, timer, input logic [2:0] dia,
                                input logic ampm, fmt, tend);
        vec_t v;
        v.regs    = {st, th, tm, ts, wd, yr, mon, day, hour, min, sec};
        v.e.hora  = hora;
        v.e.fecha = fecha;
        v.e.timer = timer;
        v.e.dia   = dia;
        v.e.ampm  = ampm;
        v.e.fmt   = fmt;
        v.e.tend  = tend;
        return v;
    endfunction

    vec_t             table_v [0:4];
    logic [10:0][7:0] rnd;
    exp_t             rnd_e;
    logic             flag_a, flag_b;

    initial begin
        table_v[0] = mk(8'h45, 8'h30, 8'h92, 8'h15, 8'h08, 8'h24, 8'h05, 8'h10, 8'h20, 8'h03, 8'h01,
                        24'h123045, 24'h150824, 24'h032010, 3'd5, 1'b0, 1'b1, 1'b1);
        table_v[1] = mk(8'h00, 8'h59, 8'hB1, 8'h31, 8'h12, 8'h99, 8'h07, 8'h59, 8'h59, 8'h23, 8'h00,
                        24'h115900, 24'h311299, 24'h235959, 3'd7, 1'b1, 1'b1, 1'b0);
        table_v[2] = mk(8'h07, 8'h08, 8'h23, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC2, 8'hFE,
                        24'h230807, 24'h010100, 24'h020000, 3'd0, 1'b0, 1'b0, 1'b0);
        table_v[3] = mk(8'h00, 8'h00, 8'h72, 8'hAA, 8'hBB, 8'hCC, 8'hFD, 8'h12, 8'h34, 8'hFF, 8'hFF,
                        24'h320000, 24'hAABBCC, 24'h3F3412, 3'd5, 1'b0, 1'b0, 1'b1);
        table_v[4] = mk(8'h11, 8'h22, 8'hE9, 8'h28, 8'h02, 8'h25, 8'h01, 8'h00, 8'h01, 8'h40, 8'h00,
                        24'h092211, 24'h280225, 24'h000100, 3'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) rtc_regs[i] = 8'h00;

        // Reset state
        #2 reset = 1'b0;
        step(3);
        check("rst_outputs", 32'(|cur_outs), 32'd0);
        check("rst_busy_done", {30'd0, busy, sweep_done}, 32'd0);
        check("rst_drive", {23'd0, bus.ad_out, bus.ad_oe}, 32'd0);
        check("rst_strobes", {28'd0, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d}, 32'b1110);

        // First sweep timing after reset release
        apply_stimulus(table_v[0].regs);
        reset  = 1'b1;
        flag_a = 1'b0;
        for (int i = 1; i < REFRESH; i++) begin
            step(1);
            flag_a |= !bus.cs_n;
        end
        check("no_early_start", 32'(flag_a), 32'd0);
        step(1);
        check("first_addr_strobes", {28'd0, bus.cs_n, bus.a_d, bus.wr_n, bus.ad_oe}, 32'b0101);
        check("first_addr_value", 32'(bus.ad_out), 32'h21);
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int i = 1; i < 44 * T_PHASE; i++) begin
            step(1);
            flag_a |= !busy;
            flag_b |= sweep_done;
        end
        check("busy_throughout", 32'(flag_a), 32'd0);
        check("no_early_done", 32'(flag_b), 32'd0);
        check("hold_before_done", 32'(hora_bcd), 32'd0);
        step(1);
        check("done_at_88", 32'(sweep_done), 32'd1);
        check_output("vec0", table_v[0].e);
        step(1);
        check("done_one_cycle", {30'd0, sweep_done, busy}, 32'd0);

        // Table-driven sweeps
        for (int v = 1; v < 5; v++) begin
            apply_stimulus(table_v[v].regs);
            step(1);
            wait_done(500);
            check_output($sformatf("vec%0d", v), table_v[v].e);
        end

        // Randomized sweeps against the decode model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 11; i++) rnd[i] = 8'($urandom_range(0, 255));
            rnd_e = model(rnd);
            apply_stimulus(rnd);
            step(1);
            wait_done(500);
            check_output($sformatf("rnd%0d", r), rnd_e);
        end

        // Pause during the GAP of index 3 for 50 cycles
        for (int i = 0; i < 11; i++) rnd[i] = 8'($urandom_range(0, 255));
        rnd_e = model(rnd);
        apply_stimulus(rnd);
        step(1);
        wait_start(100);
        check("pause_first_addr", 32'(bus.ad_out), 32'h21);
        step(16 * T_PHASE - 1);
        pause  = 1'b1;
        flag_a = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            flag_a |= !bus.cs_n;
        end
        pause = 1'b0;
        check("pause_bus_idle", 32'(flag_a), 32'd0);
        step(1);
        check("pause_resume_cs", 32'(bus.cs_n), 32'd0);
        check("pause_resume_addr", 32'(bus.ad_out), 32'h25);
        flag_b = 1'b0;
        for (int i = 0; i < 28 * T_PHASE - 1; i++) begin
            step(1);
            flag_b |= sweep_done;
        end
        check("pause_no_early_done", 32'(flag_b), 32'd0);
        step(1);
        check("pause_done_plus50", 32'(sweep_done), 32'd1);
        check_output("pause", rnd_e);

        // Reset during DATA of index 6
        for (int i = 0; i < 11; i++) rnd[i] = 8'($urandom_range(0, 255));
        rnd_e = model(rnd);
        apply_stimulus(rnd);
        step(1);
        wait_start(100);
        step(26 * T_PHASE);
        check("mid_reset_in_data", {30'd0, bus.rd_n, bus.cs_n}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_reset_pins", {30'd0, bus.cs_n, bus.rd_n}, 32'b11);
        check("mid_reset_outputs", 32'(|cur_outs), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        step(2);
        reset  = 1'b1;
        flag_a = 1'b0;
        for (int i = 1; i < REFRESH; i++) begin
            step(1);
            flag_a |= !bus.cs_n;
        end
        check("post_reset_no_early", 32'(flag_a), 32'd0);
        step(1);
        check("post_reset_start", {23'd0, bus.cs_n, bus.ad_out}, 32'h021);
        wait_done(500);
        check_output("post_reset", rnd_e);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
